bin2bcd: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It accepts an unsigned binary value on a start pulse and produces four packed BCD digits after a fixed number of cycles. It signals completion with a one-cycle done tick. It is the reverse-direction companion of the BCD-to-binary converter and is driven by a debounced push-button tick in its board-level test circuit, with the digits shown on the four-digit seven-segment multiplexer.

---
 rtl/bcd_adj3.sv | 9 +
 rtl/bin2bcd.sv | 107 ++++++++++
 tb/tb_bin2bcd.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_adj3.sv
// Single BCD digit pre-shift correction for double-dabble: adds 3 when the digit exceeds 4.
module bcd_adj3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit > 4'd4) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, four packed digits.
//  state   | meaning
//  S_IDLE  | ready for a new operand; start loads the shift chain
//  S_OP    | correct digits then shift one bit per cycle, BIN_W cycles
//  S_DONE  | one-cycle done_tick, digits final
module bin2bcd #(
  parameter int BIN_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

  localparam int N_W = $clog2(BIN_W + 1);
  localparam int CH_W = 16 + BIN_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [N_W-1:0]   n_reg, n_next;
  logic [BIN_W-1:0] p2s_reg, p2s_next;
  logic [3:0]       bcd3_reg, bcd2_reg, bcd1_reg, bcd0_reg;
  logic [3:0]       bcd3_next, bcd2_next, bcd1_next, bcd0_next;

  logic [3:0]       w_adj3, w_adj2, w_adj1, w_adj0;
  logic [CH_W-1:0]  w_shift;

  bcd_adj3 u_adj3 (.i_digit(bcd3_reg), .o_digit(w_adj3));
  bcd_adj3 u_adj2 (.i_digit(bcd2_reg), .o_digit(w_adj2));
  bcd_adj3 u_adj1 (.i_digit(bcd1_reg), .o_digit(w_adj1));
  bcd_adj3 u_adj0 (.i_digit(bcd0_reg), .o_digit(w_adj0));

  // Whole corrected chain shifts as one vector; the thousands carry-out falls off the top.
  assign w_shift = {w_adj3, w_adj2, w_adj1, w_adj0, p2s_reg} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      n_reg     <= '0;
      p2s_reg   <= '0;
      bcd3_reg  <= '0;
      bcd2_reg  <= '0;
      bcd1_reg  <= '0;
      bcd0_reg  <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      p2s_reg   <= p2s_next;
      bcd3_reg  <= bcd3_next;
      bcd2_reg  <= bcd2_next;
      bcd1_reg  <= bcd1_next;
      bcd0_reg  <= bcd0_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    p2s_next   = p2s_reg;
    bcd3_next  = bcd3_reg;
    bcd2_next  = bcd2_reg;
    bcd1_next  = bcd1_reg;
    bcd0_next  = bcd0_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_OP;
          n_next     = N_W'(BIN_W);
          p2s_next   = bin;
          bcd3_next  = '0;
          bcd2_next  = '0;
          bcd1_next  = '0;
          bcd0_next  = '0;
        end
      end
      S_OP: begin
        bcd3_next = w_shift[CH_W-1 -: 4];
        bcd2_next = w_shift[CH_W-5 -: 4];
        bcd1_next = w_shift[CH_W-9 -: 4];
        bcd0_next = w_shift[CH_W-13 -: 4];
        p2s_next  = w_shift[BIN_W-1:0];
        n_next    = n_reg - N_W'(1);
        if (n_reg == N_W'(1))
          state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign ready     = (state_reg == S_IDLE);
  assign done_tick = (state_reg == S_DONE);
  assign bcd3      = bcd3_reg;
  assign bcd2      = bcd2_reg;
  assign bcd1      = bcd1_reg;
  assign bcd0      = bcd0_reg;

endmodule

// File: tb/tb_bin2bcd.sv
// Directed self-checking bench for bin2bcd: latency, digit values, ignored starts, reset abort, sweep.
module tb_bin2bcd;

  localparam int BIN_W = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             ready;
  logic             done_tick;
  logic [3:0]       bcd3, bcd2, bcd1, bcd0;
  logic [15:0]      dig;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign dig = {bcd3, bcd2, bcd1, bcd0};

  bin2bcd #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0)
  );

  function automatic logic [15:0] dec4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Pulses start with operand v; cyc counts the accepting edge as cycle 1.
  task automatic run_conv(input int v, output logic [15:0] d, output int cyc, output bit to);
    @(posedge clk); #1;
    bin   = BIN_W'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    to    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done_tick) begin
        to = 1'b0;
        break;
      end
    end
    d = dig;
  endtask

  task automatic test_reset;
    int seen;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++;
    if (done_tick !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done_tick); end
    tests++;
    if (dig !== 16'h0000) begin fails++; $display("FAIL reset_digits got %h want 0000", dig); end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_tick) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL idle_no_done got %0d ticks want 0", seen); end
  endtask

  task automatic test_zero;
    logic [15:0] d;
    int cyc;
    bit to;
    run_conv(0, d, cyc, to);
    tests++;
    if (to) begin fails++; $display("FAIL zero_timeout no done_tick within 40 cycles"); end
    tests++;
    if (cyc != 14) begin fails++; $display("FAIL zero_latency got %0d want 14", cyc); end
    tests++;
    if (d !== 16'h0000) begin fails++; $display("FAIL zero_digits got %h want 0000", d); end
    @(posedge clk); #1;
    tests++;
    if (ready !== 1'b1 || done_tick !== 1'b0) begin
      fails++; $display("FAIL zero_after ready=%b done=%b want 1/0", ready, done_tick);
    end
  endtask

  task automatic test_values;
    int          vals [3] = '{8191, 1234, 9};
    logic [15:0] exps [3] = '{16'h8191, 16'h1234, 16'h0009};
    logic [15:0] d;
    int cyc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], d, cyc, to);
      tests++;
      if (to || d !== exps[i] || cyc != 14) begin
        fails++;
        $display("FAIL value_%0d got %h (cyc %0d, to %0d) want %h (cyc 14)", vals[i], d, cyc, to, exps[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    int seen;
    bit to;
    @(posedge clk); #1;
    bin   = 13'd4095;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    to    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL op_ready got %b want 0", ready); end
      end
      if (cyc == 4) bin = '0;
      if (cyc == 5) begin bin = 13'd1; start = 1'b1; end
      if (cyc == 6) start = 1'b0;
      if (done_tick) begin to = 1'b0; break; end
    end
    tests++;
    if (to || cyc != 14 || dig !== 16'h4095) begin
      fails++; $display("FAIL ignore_result got %h cyc %0d want 4095 cyc 14", dig, cyc);
    end
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_tick) seen++;
    end
    tests++;
    if (seen != 0 || dig !== 16'h4095 || ready !== 1'b1) begin
      fails++; $display("FAIL ignore_extra ticks %0d digits %h ready %b want 0/4095/1", seen, dig, ready);
    end
  endtask

  task automatic test_mid_reset;
    logic [15:0] d;
    int cyc;
    int seen;
    bit to;
    seen = 0;
    @(posedge clk); #1;
    bin   = 13'd5000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_tick) seen++;
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || dig !== 16'h0000) begin
      fails++; $display("FAIL async_reset ready %b done %b digits %h want 1/0/0000", ready, done_tick, dig);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_tick) seen++;
    end
    tests++;
    if (seen != 0 || dig !== 16'h0000 || ready !== 1'b1) begin
      fails++; $display("FAIL abort_state ticks %0d digits %h ready %b want 0/0000/1", seen, dig, ready);
    end
    run_conv(42, d, cyc, to);
    tests++;
    if (to || d !== 16'h0042 || cyc != 14) begin
      fails++; $display("FAIL after_reset got %h cyc %0d want 0042 cyc 14", d, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int vals[$];
    int n;
    bit found;
    for (int v = 0; v < 600; v++) vals.push_back(v);
    for (int v = 7600; v < 8192; v++) vals.push_back(v);
    @(posedge clk); #1;
    bin   = BIN_W'(vals[0]);
    start = 1'b1;
    for (int idx = 0; idx < vals.size(); idx++) begin
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        n++;
        if (done_tick) begin found = 1'b1; break; end
      end
      tests++;
      if (!found || dig !== dec4(vals[idx]) || n != ((idx == 0) ? 14 : 15)) begin
        fails++;
        $display("FAIL sweep_%0d got %h spacing %0d found %0d want %h", vals[idx], dig, n, found, dec4(vals[idx]));
      end
      if (!found) break;
      if (idx + 1 < vals.size()) bin = BIN_W'(vals[idx + 1]);
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
